multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Multicycle control FSM that drives the datapath strobes the CPU core consumes:
//  reg_dst, reg_write, alu_src, mem_write, mem_to_reg and alu_ctrl, plus PC/IR sequencing strobes.
//  Decodes opcode/funct from the datapath instruction register and steps each instruction
//  through FETCH..writeback, one state per clock. It sits beside the datapath inside CPU.
// PARAMETERS
//  ILLEGAL_TRAP  1  1: an illegal opcode parks the FSM in HALT until reset; 0: pulse illegal, return to FETCH
// PORTS
//  clock         in   1  single system clock, rising edge
//  reset         in   1  asynchronous, active-high; FSM -> FETCH, all write strobes forced 0 while high
//  clock_enable  in   1  0 = stall: state holds and all write strobes are forced 0
//  opcode        in   6  instr[31:26], valid from DECODE onward (IR loaded at end of FETCH)
//  funct         in   6  instr[5:0]
//  zero          in   1  ALU zero flag, sampled in BRANCH
//  ir_write      out  1  load instruction register
//  pc_write      out  1  unconditional PC load
//  pc_src        out  2  0 = ALU result (pc+4), 1 = ALU out reg (branch target), 2 = jump target
//  i_or_d        out  1  memory address: 0 = PC, 1 = ALU out
//  reg_dst       out  1  write register: 1 = rd, 0 = rt
//  reg_write     out  1  register file write enable
//  alu_src_a     out  1  0 = PC, 1 = rs
//  alu_src_b     out  2  0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
//  alu_src       out  1  alu_src_b==2 (kept for the single-cycle datapath port)
//  mem_write     out  1  data memory write enable
//  mem_to_reg    out  1  write-back data: 1 = memory, 0 = ALU out
//  alu_ctrl      out  4  AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100
//  illegal       out  1  one-cycle pulse in DECODE when the opcode is unsupported
//  halted        out  1  high while in HALT
// BEHAVIOUR
//  - Outputs are Moore: decoded from the registered state only. Strobes are ir_write, pc_write,
//    reg_write and mem_write. They are ANDed with ~reset and clock_enable.
//  - Reset (async): state = FETCH. While reset is high all strobes are 0, the other outputs follow
//    FETCH decode, and illegal = halted = 0. Reset mid-instruction abandons it with no partial write.
//  - FETCH:     i_or_d=0, ir_write=1, alu_src_a=0, alu_src_b=1, ADD, pc_src=0, pc_write=1 -> DECODE
//  - DECODE:    alu_src_a=0, alu_src_b=3, ADD (branch target precompute). Next state by opcode:
//    000000 R -> EXECUTE; 100011 lw / 101011 sw -> MEM_ADR; 000100 beq -> BRANCH;
//    001000 addi -> ADDI_EX; 000010 j -> JUMP;
//    other -> illegal=1, then HALT if ILLEGAL_TRAP else FETCH
//  - MEM_ADR:   alu_src_a=1, alu_src_b=2, ADD -> MEM_RD (lw) / MEM_WR (sw)
//  - MEM_RD:    i_or_d=1 -> MEM_WB;  MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH
//  - MEM_WR:    i_or_d=1, mem_write=1 -> FETCH
//  - EXECUTE:   alu_src_a=1, alu_src_b=0, alu_ctrl from funct -> ALU_WB
//  - ALU_WB:    reg_dst=1, mem_to_reg=0, reg_write=1 -> FETCH
//  - ADDI_EX:   alu_src_a=1, alu_src_b=2, ADD -> ADDI_WB
//  - ADDI_WB:   reg_dst=0, mem_to_reg=0, reg_write=1 -> FETCH
//  - BRANCH:    alu_src_a=1, alu_src_b=0, SUB, pc_src=1, pc_write=zero -> FETCH
//  - JUMP:      pc_src=2, pc_write=1 -> FETCH
//  - HALT:      all strobes 0, halted=1; left only by reset
//  - funct decode: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT.
//    Unknown funct gives ADD; this is not flagged illegal.
//  - Latency in enabled cycles: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
//  - clock_enable=0 at any state (including HALT) freezes state; strobes resume when it returns to 1.
//  - Non-strobe outputs in states that do not name them: 0 (alu_ctrl defaults to ADD).
// STRUCTURE
//  - cpu_ctrl_pkg: state_t enum (FETCH..HALT, 4-bit), opcode localparams,
//    funct localparams, alu_ctrl codes, alu_op_t {ALU_ADD, ALU_SUB, ALU_FUNCT}.
//  - Sub-module alu_decoder (alu_op_t, funct -> alu_ctrl), purely combinational.
//    It is reused by the single-cycle CPU.
//  - Structure: one state register, next-state always_comb, output-decode always_comb, strobe gating.
// TESTING
//  1. Release reset, opcode=100011 (lw), clock_enable=1 -> states FETCH,DECODE,MEM_ADR,MEM_RD,MEM_WB.
//     reg_write=1,mem_to_reg=1,reg_dst=0 only in cycle 5, then FETCH.
//  2. opcode=000000, funct=100010 -> alu_ctrl=0110 in EXECUTE; ALU_WB reg_dst=1, reg_write=1; 4 cycles.
//  3. beq with zero=1 -> pc_write=1,pc_src=1 in cycle 3. Repeat with zero=0: pc_write=0 in BRANCH.
//  4. sw, drop clock_enable for 3 cycles in MEM_ADR -> state held, mem_write stays 0.
//     mem_write=1 on the cycle after re-enable.
//  5. opcode=111111, ILLEGAL_TRAP=1 -> illegal pulses 1 cycle, halted=1 stays, no strobes for 20 cycles.
//     Reset returns FETCH.
//  6. Assert reset asynchronously in MEM_WB (between edges) -> reg_write drops immediately.
//     State=FETCH, pc_write=0 until release.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the CPU control path (multicycle FSM and single-cycle ALU decode).
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEM_ADR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    EXECUTE,
    ALU_WB,
    ADDI_EX,
    ADDI_WB,
    BRANCH,
    JUMP,
    HALT
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_FUNCT
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from the FSM's ALU operation class and the R-type funct field.
module alu_decoder
  import cpu_ctrl_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl
);

  always_comb begin
    alu_ctrl = CTRL_ADD;
    case (alu_op)
      ALU_SUB: alu_ctrl = CTRL_SUB;
      ALU_FUNCT: begin
        // Unrecognised funct codes fall back to ADD without raising illegal.
        case (funct)
          FN_ADD:  alu_ctrl = CTRL_ADD;
          FN_SUB:  alu_ctrl = CTRL_SUB;
          FN_AND:  alu_ctrl = CTRL_AND;
          FN_OR:   alu_ctrl = CTRL_OR;
          FN_NOR:  alu_ctrl = CTRL_NOR;
          FN_SLT:  alu_ctrl = CTRL_SLT;
          default: alu_ctrl = CTRL_ADD;
        endcase
      end
      default: alu_ctrl = CTRL_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: one state per clock, Moore-decoded datapath controls with gated write strobes.
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clock_enable,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       alu_src,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic [3:0] alu_ctrl,
  output logic       illegal,
  output logic       halted
);

  state_t  state;
  state_t  state_next;
  alu_op_t alu_op;
  logic    opcode_legal;
  logic    ir_write_d;
  logic    pc_write_d;
  logic    reg_write_d;
  logic    mem_write_d;
  logic    strobe_en;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else if (clock_enable) begin
      state <= state_next;
    end
  end

  always_comb begin
    opcode_legal = 1'b0;
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: opcode_legal = 1'b1;
      default:                                     opcode_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH: state_next = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     state_next = EXECUTE;
          OP_LW, OP_SW: state_next = MEM_ADR;
          OP_BEQ:       state_next = BRANCH;
          OP_ADDI:      state_next = ADDI_EX;
          OP_J:         state_next = JUMP;
          default:      state_next = ILLEGAL_TRAP ? HALT : FETCH;
        endcase
      end
      MEM_ADR: state_next = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:  state_next = MEM_WB;
      EXECUTE: state_next = ALU_WB;
      ADDI_EX: state_next = ADDI_WB;
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    ir_write_d  = 1'b0;
    pc_write_d  = 1'b0;
    reg_write_d = 1'b0;
    mem_write_d = 1'b0;
    pc_src      = 2'd0;
    i_or_d      = 1'b0;
    reg_dst     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'd0;
    mem_to_reg  = 1'b0;
    alu_op      = ALU_ADD;
    case (state)
      FETCH: begin
        ir_write_d = 1'b1;
        pc_write_d = 1'b1;
        alu_src_b  = 2'd1;
      end
      DECODE: alu_src_b = 2'd3;
      MEM_ADR, ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      MEM_RD: i_or_d = 1'b1;
      MEM_WB: begin
        mem_to_reg  = 1'b1;
        reg_write_d = 1'b1;
      end
      MEM_WR: begin
        i_or_d      = 1'b1;
        mem_write_d = 1'b1;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      ALU_WB: begin
        reg_dst     = 1'b1;
        reg_write_d = 1'b1;
      end
      ADDI_WB: reg_write_d = 1'b1;
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = 2'd1;
        pc_write_d = zero;
      end
      JUMP: begin
        pc_src     = 2'd2;
        pc_write_d = 1'b1;
      end
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op   (alu_op),
    .funct    (funct),
    .alu_ctrl (alu_ctrl)
  );

  // Reset gating is combinational so an async reset kills strobes before the next edge.
  assign strobe_en = ~reset & clock_enable;
  assign ir_write  = ir_write_d  & strobe_en;
  assign pc_write  = pc_write_d  & strobe_en;
  assign reg_write = reg_write_d & strobe_en;
  assign mem_write = mem_write_d & strobe_en;
  assign alu_src   = (alu_src_b == 2'd2);
  assign illegal   = (state == DECODE) & ~opcode_legal & ~reset;
  assign halted    = (state == HALT) & ~reset;

endmodule
